// File: rtl/bus_reg_slice.sv
// Bus_if register slice: one 2-entry skid buffer on the request path and one
// on the response path, plus an outstanding-request limiter so the response
// path can never be asked to hold more than the downstream slave owes.

// Simulation-only protocol checks for the slice.
module bus_reg_slice_chk (
  input logic       clk_i,
  input logic       rst_i,
  input logic [2:0] cmd_i,
  input logic       rsp_hs_i,
  input logic       cnt_zero_i
);

  a_cmd_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (cmd_i == 3'b000) || (cmd_i == 3'b001) || (cmd_i == 3'b010))
    else $error("bus_reg_slice: illegal s_MCmd %0b ignored", cmd_i);

  a_rsp_owed: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_hs_i && cnt_zero_i))
    else $error("bus_reg_slice: response received with nothing outstanding");

endmodule

module bus_reg_slice #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WRITERESP       = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [2:0]              s_MCmd,
  input  logic [ADDR_WIDTH-1:0]   s_MAddr,
  input  logic [DATA_WIDTH-1:0]   s_MData,
  input  logic [DATA_WIDTH/8-1:0] s_MByteEn,
  output logic                    s_SCmdAccept,
  output logic [1:0]              s_SResp,
  output logic [DATA_WIDTH-1:0]   s_SData,
  input  logic                    s_MRespAccept,
  output logic [2:0]              m_MCmd,
  output logic [ADDR_WIDTH-1:0]   m_MAddr,
  output logic [DATA_WIDTH-1:0]   m_MData,
  output logic [DATA_WIDTH/8-1:0] m_MByteEn,
  input  logic                    m_SCmdAccept,
  input  logic [1:0]              m_SResp,
  input  logic [DATA_WIDTH-1:0]   m_SData,
  output logic                    m_MRespAccept
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [4:0]  MAX_OUT_C = 5'(MAX_OUTSTANDING);
  localparam logic [2:0]  CMD_IDLE  = 3'b000;
  localparam logic [2:0]  CMD_WR    = 3'b001;
  localparam logic [2:0]  CMD_RD    = 3'b010;
  localparam logic [1:0]  RESP_NULL = 2'b00;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  // A command owes a response (and occupies a response slot) if it is a
  // read, or a write when writes are acknowledged.
  function automatic logic is_counted(input logic [2:0] cmd);
    logic hit;
    hit = 1'b0;
    case (cmd)
      CMD_RD:  hit = 1'b1;
      CMD_WR:  hit = (WRITERESP != 32'd0);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  req_t       req_main_q, req_main_d, req_skid_q, req_skid_d, s_req_s;
  logic       req_skid_vld_q, req_skid_vld_d;
  rsp_t       rsp_main_q, rsp_main_d, rsp_skid_q, rsp_skid_d, m_rsp_s;
  logic       rsp_skid_vld_q, rsp_skid_vld_d;
  logic [3:0] cnt_q, cnt_d;
  logic       s_accept_q, s_accept_d;
  logic       m_rsp_accept_q, m_rsp_accept_d;
  logic [1:0] queued_d;
  logic [4:0] inflight_d;
  logic       stall_d;
  logic       s_cmd_legal_s, up_req_hs_s, dn_req_hs_s, cnt_inc_s;
  logic       dn_rsp_hs_s, up_rsp_hs_s, req_main_vld_s, rsp_main_vld_s;

  assign s_req_s         = '{cmd: s_MCmd, addr: s_MAddr, data: s_MData, be: s_MByteEn};
  assign m_rsp_s         = '{resp: m_SResp, data: m_SData};
  assign s_cmd_legal_s   = (s_MCmd == CMD_WR) || (s_MCmd == CMD_RD);
  assign req_main_vld_s  = (req_main_q.cmd != CMD_IDLE);
  assign rsp_main_vld_s  = (rsp_main_q.resp != RESP_NULL);
  assign up_req_hs_s     = s_cmd_legal_s && s_accept_q;
  assign dn_req_hs_s     = req_main_vld_s && m_SCmdAccept;
  assign dn_rsp_hs_s     = (m_SResp != RESP_NULL) && m_rsp_accept_q;
  assign up_rsp_hs_s     = rsp_main_vld_s && s_MRespAccept;
  assign cnt_inc_s       = dn_req_hs_s && is_counted(req_main_q.cmd);

  // Request skid buffer: main register drives m_*, skid catches one extra.
  always_comb begin
    req_main_d     = req_main_q;
    req_skid_d     = req_skid_q;
    req_skid_vld_d = req_skid_vld_q;
    if (!req_main_vld_s || dn_req_hs_s) begin
      if (req_skid_vld_q) begin
        req_main_d     = req_skid_q;
        req_skid_vld_d = up_req_hs_s;
        req_skid_d     = up_req_hs_s ? s_req_s : req_skid_q;
      end else if (up_req_hs_s) begin
        req_main_d = s_req_s;
      end else begin
        // Empty: drop the command but leave addr/data where they were.
        req_main_d.cmd = CMD_IDLE;
      end
    end else if (up_req_hs_s) begin
      req_skid_d     = s_req_s;
      req_skid_vld_d = 1'b1;
    end else begin
      req_skid_vld_d = req_skid_vld_q;
    end
  end

  // Response skid buffer, mirror image of the request path.
  always_comb begin
    rsp_main_d     = rsp_main_q;
    rsp_skid_d     = rsp_skid_q;
    rsp_skid_vld_d = rsp_skid_vld_q;
    if (!rsp_main_vld_s || up_rsp_hs_s) begin
      if (rsp_skid_vld_q) begin
        rsp_main_d     = rsp_skid_q;
        rsp_skid_vld_d = dn_rsp_hs_s;
        rsp_skid_d     = dn_rsp_hs_s ? m_rsp_s : rsp_skid_q;
      end else if (dn_rsp_hs_s) begin
        rsp_main_d = m_rsp_s;
      end else begin
        rsp_main_d.resp = RESP_NULL;
      end
    end else if (dn_rsp_hs_s) begin
      rsp_skid_d     = m_rsp_s;
      rsp_skid_vld_d = 1'b1;
    end else begin
      rsp_skid_vld_d = rsp_skid_vld_q;
    end
  end

  // Outstanding count and the registered accept signals, all from next-state
  // so the flops reflect the situation of the following cycle.
  always_comb begin
    cnt_d = cnt_q;
    case ({cnt_inc_s, dn_rsp_hs_s})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
      default: cnt_d = cnt_q;
    endcase
    queued_d = {1'b0, is_counted(req_main_d.cmd)}
             + {1'b0, (req_skid_vld_d && is_counted(req_skid_d.cmd))};
    inflight_d     = {1'b0, cnt_d} + {3'b000, queued_d};
    stall_d        = (inflight_d >= MAX_OUT_C);
    s_accept_d     = !req_skid_vld_d && !stall_d;
    m_rsp_accept_d = !rsp_skid_vld_d;
  end

  // Request path registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_main_q     <= '0;
      req_skid_q     <= '0;
      req_skid_vld_q <= 1'b0;
    end else begin
      req_main_q     <= req_main_d;
      req_skid_q     <= req_skid_d;
      req_skid_vld_q <= req_skid_vld_d;
    end
  end

  // Response path registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_main_q     <= '0;
      rsp_skid_q     <= '0;
      rsp_skid_vld_q <= 1'b0;
    end else begin
      rsp_main_q     <= rsp_main_d;
      rsp_skid_q     <= rsp_skid_d;
      rsp_skid_vld_q <= rsp_skid_vld_d;
    end
  end

  // Counter and flow-control flops; both accepts come up high out of reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q          <= 4'd0;
      s_accept_q     <= 1'b1;
      m_rsp_accept_q <= 1'b1;
    end else begin
      cnt_q          <= cnt_d;
      s_accept_q     <= s_accept_d;
      m_rsp_accept_q <= m_rsp_accept_d;
    end
  end

  assign m_MCmd        = req_main_q.cmd;
  assign m_MAddr       = req_main_q.addr;
  assign m_MData       = req_main_q.data;
  assign m_MByteEn     = req_main_q.be;
  assign s_SResp       = rsp_main_q.resp;
  assign s_SData       = rsp_main_q.data;
  assign s_SCmdAccept  = s_accept_q;
  assign m_MRespAccept = m_rsp_accept_q;

  bus_reg_slice_chk u_chk (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .cmd_i      (s_MCmd),
    .rsp_hs_i   (dn_rsp_hs_s),
    .cnt_zero_i (cnt_q == 4'd0)
  );

endmodule

// File: tb/tb_bus_reg_slice.sv
// Scoreboard bench for bus_reg_slice: a driver plays upstream master and
// downstream slave, a separate monitor checks ordering, flow control,
// stability and reset behaviour against occupancy counters.
module tb_bus_reg_slice;

  localparam int MAX = 4;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  s_MCmd;
  logic [31:0] s_MAddr, s_MData;
  logic [3:0]  s_MByteEn;
  logic        s_SCmdAccept;
  logic [1:0]  s_SResp;
  logic [31:0] s_SData;
  logic        s_MRespAccept;
  logic [2:0]  m_MCmd;
  logic [31:0] m_MAddr, m_MData;
  logic [3:0]  m_MByteEn;
  logic        m_SCmdAccept;
  logic [1:0]  m_SResp;
  logic [31:0] m_SData;
  logic        m_MRespAccept;

  bus_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX), .WRITERESP(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData), .s_MByteEn(s_MByteEn),
    .s_SCmdAccept(s_SCmdAccept), .s_SResp(s_SResp), .s_SData(s_SData),
    .s_MRespAccept(s_MRespAccept),
    .m_MCmd(m_MCmd), .m_MAddr(m_MAddr), .m_MData(m_MData), .m_MByteEn(m_MByteEn),
    .m_SCmdAccept(m_SCmdAccept), .m_SResp(m_SResp), .m_SData(m_SData),
    .m_MRespAccept(m_MRespAccept)
  );

  initial forever #5 Clk = ~Clk;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  rsp_t dn_pend[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc, fwd, rin, rout, drain_cyc;
  bit   drain_req = 1'b0;
  bit   drain_done = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output checked at the falling edge against occupancy counts.
  initial begin
    req_t cur_req, prev_req, er;
    rsp_t cur_rsp, prev_rsp, ep;
    bit   prev_req_stall, prev_rsp_stall;
    acc = 0; fwd = 0; rin = 0; rout = 0; drain_cyc = 0;
    prev_req_stall = 1'b0; prev_rsp_stall = 1'b0;
    prev_req = '0; prev_rsp = '0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        chk("reset_outputs",
            128'({m_MCmd, m_MAddr, m_MData, m_MByteEn, s_SResp, s_SData, s_SCmdAccept, m_MRespAccept}),
            128'({3'd0, 32'd0, 32'd0, 4'd0, 2'd0, 32'd0, 1'b1, 1'b1}));
        exp_req.delete();
        exp_rsp.delete();
        acc = 0; fwd = 0; rin = 0; rout = 0;
        prev_req_stall = 1'b0; prev_rsp_stall = 1'b0;
      end else begin
        cur_req = {m_MCmd, m_MAddr, m_MData, m_MByteEn};
        cur_rsp = {s_SResp, s_SData};
        chk("m_cmd_valid", 128'(m_MCmd != 3'd0), 128'((acc - fwd) >= 1));
        chk("s_cmd_accept", 128'(s_SCmdAccept), 128'(((acc - fwd) < 2) && ((acc - rin) < MAX)));
        chk("s_resp_valid", 128'(s_SResp != 2'd0), 128'((rin - rout) >= 1));
        chk("m_resp_accept", 128'(m_MRespAccept), 128'((rin - rout) < 2));
        if (prev_req_stall) chk("m_req_stable", 128'(cur_req), 128'(prev_req));
        if (prev_rsp_stall) chk("s_resp_stable", 128'(cur_rsp), 128'(prev_rsp));
        if (m_MCmd != 3'd0 && m_SCmdAccept) begin
          if (exp_req.size() == 0) chk("req_unexpected", 128'(cur_req), 128'(0));
          else begin
            er = exp_req.pop_front();
            chk("req_order", 128'(cur_req), 128'(er));
          end
        end
        if (s_SResp != 2'd0 && s_MRespAccept) begin
          if (exp_rsp.size() == 0) chk("resp_unexpected", 128'(cur_rsp), 128'(0));
          else begin
            ep = exp_rsp.pop_front();
            chk("resp_order", 128'(cur_rsp), 128'(ep));
          end
        end
        prev_req_stall = (m_MCmd != 3'd0) && !m_SCmdAccept;
        prev_rsp_stall = (s_SResp != 2'd0) && !s_MRespAccept;
        prev_req = cur_req;
        prev_rsp = cur_rsp;
        acc  += int'((s_MCmd == 3'd1 || s_MCmd == 3'd2) && s_SCmdAccept);
        fwd  += int'(m_MCmd != 3'd0 && m_SCmdAccept);
        rin  += int'(m_SResp != 2'd0 && m_MRespAccept);
        rout += int'(s_SResp != 2'd0 && s_MRespAccept);
        if (drain_req && !drain_done) begin
          drain_cyc++;
          if (exp_req.size() == 0 && exp_rsp.size() == 0 && dn_pend.size() == 0 &&
              m_MCmd == 3'd0 && s_SResp == 2'd0) begin
            chk("drain_all_delivered", 128'(acc - rout), 128'(0));
            drain_done = 1'b1;
          end else if (drain_cyc > 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d req %0d resp %0d pend still queued, required 0",
                     exp_req.size(), exp_rsp.size(), dn_pend.size());
            drain_done = 1'b1;
          end
        end
      end
    end
  end

  // Driver: upstream master, downstream slave and response sink.
  initial begin
    bit   up_hs, dn_hs, rs_hs, presenting, first_rd, issue, resp_en;
    int   wr_n;
    req_t r;
    rsp_t p;
    Reset = 1'b1; s_MCmd = 3'd0; s_MAddr = 32'd0; s_MData = 32'd0; s_MByteEn = 4'd0;
    s_MRespAccept = 1'b1; m_SCmdAccept = 1'b1; m_SResp = 2'd0; m_SData = 32'd0;
    presenting = 1'b0; first_rd = 1'b1; wr_n = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int cyc = 0; !drain_done; cyc++) begin
      @(negedge Clk);
      up_hs = !Reset && (s_MCmd == 3'd1 || s_MCmd == 3'd2) && s_SCmdAccept;
      dn_hs = !Reset && (m_MCmd != 3'd0) && m_SCmdAccept;
      rs_hs = !Reset && (m_SResp != 2'd0) && m_MRespAccept;
      if (up_hs) begin
        r = {s_MCmd, s_MAddr, s_MData, s_MByteEn};
        exp_req.push_back(r);
      end
      if (dn_hs) begin
        if (m_MCmd == 3'd2) begin
          p.resp = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b01;
          p.data = first_rd ? 32'hCAFEF00D : 32'($urandom);
          first_rd = 1'b0;
        end else begin
          p.resp = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
          p.data = 32'd0;
        end
        dn_pend.push_back(p);
      end
      if (rs_hs) begin
        exp_rsp.push_back(dn_pend.pop_front());
        presenting = 1'b0;
      end
      @(posedge Clk);
      #1;
      if (cyc == 157) begin
        Reset = 1'b1; s_MCmd = 3'd0; m_SResp = 2'd0;
        presenting = 1'b0; dn_pend.delete();
      end
      if (cyc == 159) Reset = 1'b0;
      // Default knobs, then per-phase overrides.
      m_SCmdAccept = 1'b1; s_MRespAccept = 1'b1; resp_en = 1'b1; issue = 1'b1;
      if (cyc < 15) issue = (cyc == 0);
      else if (cyc < 35) issue = (wr_n < 8);
      else if (cyc < 65) m_SCmdAccept = !(cyc >= 40 && cyc <= 44);
      else if (cyc < 110) resp_en = (cyc >= 90);
      else if (cyc < 140) s_MRespAccept = !(cyc >= 115 && cyc <= 118);
      else if (cyc < 160) begin
        s_MRespAccept = 1'b0;
        m_SCmdAccept  = (cyc < 150) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (cyc < 1500) begin
        issue         = ($urandom_range(0, 9) < 7);
        m_SCmdAccept  = ($urandom_range(0, 3) != 0);
        s_MRespAccept = ($urandom_range(0, 3) != 0);
        resp_en       = ((cyc / 50) % 5 == 3) ? 1'b0 : ($urandom_range(0, 9) < 7);
      end else begin
        issue = 1'b0;
        drain_req = 1'b1;
      end
      if (Reset) begin
        s_MCmd = 3'd0;
      end else if (up_hs || s_MCmd == 3'd0) begin
        if (issue) begin
          s_MAddr   = 32'($urandom);
          s_MData   = 32'($urandom);
          s_MByteEn = 4'($urandom_range(0, 15));
          s_MCmd    = 3'($urandom_range(1, 2));
          if (cyc < 15) begin
            s_MCmd = 3'd2; s_MAddr = 32'h10;
          end else if (cyc < 35) begin
            s_MCmd = 3'd1; s_MAddr = 32'(wr_n); wr_n++;
          end else if (cyc >= 65 && cyc < 110) begin
            s_MCmd = 3'd2;
          end
        end else begin
          s_MCmd = 3'd0;
        end
      end
      if (!presenting) begin
        if (!Reset && resp_en && dn_pend.size() > 0) begin
          m_SResp = dn_pend[0].resp;
          m_SData = dn_pend[0].data;
          presenting = 1'b1;
        end else begin
          m_SResp = 2'd0;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
